// File: rtl/vproc_vreg_wr_arb.sv
// Vector register file write-port arbiter: fixed-priority or round-robin selection with aging,
// winning write registered onto the single vregfile write port one cycle after the handshake.
module vproc_vreg_wr_arb #(
  parameter int unsigned  VREG_W         = 128,
  parameter int unsigned  PIPE_CNT       = 4,
  parameter logic         ROUND_ROBIN    = 1'b0,
  parameter int unsigned  STARVE_LIMIT   = 3,
  parameter logic         DONT_CARE_ZERO = 1'b0,
  localparam int unsigned IDX_W          = (PIPE_CNT > 1) ? $clog2(PIPE_CNT) : 1
) (
  input  logic                               clk_i,
  input  logic                               sync_rst_ni,
  input  logic                               wr_block_i,
  input  logic [PIPE_CNT-1:0]                req_valid_i,
  output logic [PIPE_CNT-1:0]                req_ready_o,
  input  logic [PIPE_CNT-1:0][4:0]           req_addr_i,
  input  logic [PIPE_CNT-1:0][VREG_W/8-1:0]  req_be_i,
  input  logic [PIPE_CNT-1:0][VREG_W-1:0]    req_data_i,
  output logic                               vregfile_wr_en_o,
  output logic [4:0]                         vregfile_wr_addr_o,
  output logic [VREG_W/8-1:0]                vregfile_wr_be_o,
  output logic [VREG_W-1:0]                  vregfile_wr_data_o,
  output logic [IDX_W-1:0]                   grant_idx_o
);

  localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [PIPE_CNT-1:0][CNT_W-1:0] wait_cnt_q;
  logic [IDX_W-1:0]               ptr_q;

  logic                           aged_p0;
  logic                           vld_p0;
  logic [IDX_W-1:0]               idx_p0;
  logic [IDX_W-1:0]               rr_sel;

  logic                           vld_p1;
  logic [4:0]                     addr_p1;
  logic [VREG_W/8-1:0]            be_p1;
  logic [VREG_W-1:0]              data_p1;
  logic [IDX_W-1:0]               idx_p1;

  // Stage p0: grant selection; a starved requester overrides the normal policy
  always_comb begin
    aged_p0     = 1'b0;
    vld_p0      = 1'b0;
    idx_p0      = '0;
    rr_sel      = '0;
    req_ready_o = '0;
    for (int unsigned i = 0; i < PIPE_CNT; i++) begin
      if (!aged_p0 && req_valid_i[IDX_W'(i)] && wait_cnt_q[IDX_W'(i)] == CNT_MAX) begin
        aged_p0 = 1'b1;
        idx_p0  = IDX_W'(i);
      end
    end
    vld_p0 = aged_p0;
    for (int unsigned i = 0; i < PIPE_CNT; i++) begin
      if (ROUND_ROBIN) begin
        rr_sel = IDX_W'((32'(ptr_q) + i) % PIPE_CNT);
      end else begin
        rr_sel = IDX_W'(i);
      end
      if (!vld_p0 && req_valid_i[rr_sel]) begin
        vld_p0 = 1'b1;
        idx_p0 = rr_sel;
      end
    end
    if (wr_block_i || !sync_rst_ni) begin
      vld_p0 = 1'b0;
    end
    if (vld_p0) begin
      req_ready_o[idx_p0] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      ptr_q      <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (ROUND_ROBIN && vld_p0) begin
        ptr_q <= IDX_W'((32'(idx_p0) + 1) % PIPE_CNT);
      end
      for (int unsigned i = 0; i < PIPE_CNT; i++) begin
        if (!req_valid_i[IDX_W'(i)] || (vld_p0 && idx_p0 == IDX_W'(i))) begin
          wait_cnt_q[IDX_W'(i)] <= '0;
        end else if (!wr_block_i && wait_cnt_q[IDX_W'(i)] != CNT_MAX) begin
          wait_cnt_q[IDX_W'(i)] <= wait_cnt_q[IDX_W'(i)] + CNT_W'(1);
        end
      end
    end
  end

  // Stage p1: registered write towards the register file
  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      be_p1   <= '0;
      data_p1 <= '0;
      idx_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        addr_p1 <= req_addr_i[idx_p0];
        be_p1   <= req_be_i[idx_p0];
        data_p1 <= req_data_i[idx_p0];
        idx_p1  <= idx_p0;
      end else if (DONT_CARE_ZERO) begin
        addr_p1 <= '0;
        be_p1   <= '0;
        data_p1 <= '0;
        idx_p1  <= '0;
      end
    end
  end

  assign vregfile_wr_en_o   = vld_p1;
  assign vregfile_wr_addr_o = addr_p1;
  assign vregfile_wr_be_o   = be_p1;
  assign vregfile_wr_data_o = data_p1;
  assign grant_idx_o        = idx_p1;

endmodule

// File: tb/tb_vproc_vreg_wr_arb.sv
// Bench for vproc_vreg_wr_arb: three instances (fixed priority, round-robin with zeroing, single pipe)
// driven by directed vectors; expected writes are queued at issue and checked by a separate monitor.
module tb_vproc_vreg_wr_arb;

  typedef struct {
    int           d;
    int           idx;
    logic [4:0]   addr;
    logic [15:0]  be;
    logic [127:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  blk   [3];
  logic [3:0]            vld   [3];
  logic [3:0][4:0]       paddr [3];
  logic [3:0][15:0]      pbe   [3];
  logic [3:0][127:0]     pdata [3];

  logic [3:0]   rdy0, rdy1;
  logic [0:0]   rdy2;
  logic         en0, en1, en2;
  logic [4:0]   wa0, wa1, wa2;
  logic [15:0]  wb0, wb1, wb2;
  logic [127:0] wd0, wd1, wd2;
  logic [1:0]   gi0, gi1;
  logic [0:0]   gi2;

  logic [3:0]   rdy   [3];
  logic         en    [3];
  logic [4:0]   waddr [3];
  logic [15:0]  wbe   [3];
  logic [127:0] wdata [3];
  logic [1:0]   gidx  [3];

  always_comb begin
    rdy[0] = rdy0;  rdy[1] = rdy1;  rdy[2] = {3'b000, rdy2};
    en[0] = en0;    en[1] = en1;    en[2] = en2;
    waddr[0] = wa0; waddr[1] = wa1; waddr[2] = wa2;
    wbe[0] = wb0;   wbe[1] = wb1;   wbe[2] = wb2;
    wdata[0] = wd0; wdata[1] = wd1; wdata[2] = wd2;
    gidx[0] = gi0;  gidx[1] = gi1;  gidx[2] = {1'b0, gi2};
  end

  vproc_vreg_wr_arb #(.VREG_W(128), .PIPE_CNT(4), .ROUND_ROBIN(1'b0), .STARVE_LIMIT(3),
                      .DONT_CARE_ZERO(1'b0)) dut0 (
    .clk_i(clk), .sync_rst_ni(rst_n), .wr_block_i(blk[0]), .req_valid_i(vld[0]),
    .req_ready_o(rdy0), .req_addr_i(paddr[0]), .req_be_i(pbe[0]), .req_data_i(pdata[0]),
    .vregfile_wr_en_o(en0), .vregfile_wr_addr_o(wa0), .vregfile_wr_be_o(wb0),
    .vregfile_wr_data_o(wd0), .grant_idx_o(gi0));

  vproc_vreg_wr_arb #(.VREG_W(128), .PIPE_CNT(4), .ROUND_ROBIN(1'b1), .STARVE_LIMIT(3),
                      .DONT_CARE_ZERO(1'b1)) dut1 (
    .clk_i(clk), .sync_rst_ni(rst_n), .wr_block_i(blk[1]), .req_valid_i(vld[1]),
    .req_ready_o(rdy1), .req_addr_i(paddr[1]), .req_be_i(pbe[1]), .req_data_i(pdata[1]),
    .vregfile_wr_en_o(en1), .vregfile_wr_addr_o(wa1), .vregfile_wr_be_o(wb1),
    .vregfile_wr_data_o(wd1), .grant_idx_o(gi1));

  vproc_vreg_wr_arb #(.VREG_W(128), .PIPE_CNT(1), .ROUND_ROBIN(1'b0), .STARVE_LIMIT(3),
                      .DONT_CARE_ZERO(1'b0)) dut2 (
    .clk_i(clk), .sync_rst_ni(rst_n), .wr_block_i(blk[2]), .req_valid_i(vld[2][0:0]),
    .req_ready_o(rdy2), .req_addr_i(paddr[2][0:0]), .req_be_i(pbe[2][0:0]),
    .req_data_i(pdata[2][0:0]), .vregfile_wr_en_o(en2), .vregfile_wr_addr_o(wa2),
    .vregfile_wr_be_o(wb2), .vregfile_wr_data_o(wd2), .grant_idx_o(gi2));

  int   errors = 0;
  int   checks = 0;
  int   seq    = 0;
  exp_t q[$];
  exp_t mon_e;

  // Requester protocol: a pending request must not be withdrawn before its handshake
  logic [3:0] pend [2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 4; p++) begin
        if (rst_n && pend[d][p])
          assert (vld[d][p]) else $error("protocol violation dut%0d pipe%0d", d, p);
        pend[d][p] <= rst_n && vld[d][p] && !rdy[d][p];
      end
    end
  end

  // Monitor: every presented write must match the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (en[d]) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected dut%0d: got write idx=%0d addr=%0d, required no write",
                     d, gidx[d], waddr[d]);
          end else begin
            mon_e = q.pop_front();
            if (mon_e.d != d || int'(gidx[d]) != mon_e.idx || waddr[d] !== mon_e.addr ||
                wbe[d] !== mon_e.be || wdata[d] !== mon_e.data) begin
              errors++;
              $display("FAIL wr_payload dut%0d: got idx=%0d addr=%0d be=%h data=%h, required dut%0d idx=%0d addr=%0d be=%h data=%h",
                       d, gidx[d], waddr[d], wbe[d], wdata[d],
                       mon_e.d, mon_e.idx, mon_e.addr, mon_e.be, mon_e.data);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic refresh(input int d, input int p);
    seq++;
    paddr[d][p] = 5'(seq * 7 + p);
    pbe[d][p]   = 16'(seq * 4951);
    pdata[d][p] = {32'(seq), ~32'(seq), 32'(seq * 3 + d), 32'hCAFE_0000 + 32'(p)};
  endtask

  task automatic chk_rdy(input int d, input logic [3:0] exp_r);
    checks++;
    if (rdy[d] !== exp_r) begin
      errors++;
      $display("FAIL ready dut%0d: got %b, required %b", d, rdy[d], exp_r);
    end
  endtask

  // One cycle: g is the pipe expected to be granted this cycle, -1 for none
  task automatic step(input int d, input int g);
    exp_t x;
    @(negedge clk);
    chk_rdy(d, (g >= 0) ? 4'(1 << g) : 4'b0000);
    if (g >= 0) begin
      x.d = d; x.idx = g; x.addr = paddr[d][g]; x.be = pbe[d][g]; x.data = pdata[d][g];
      q.push_back(x);
    end
    @(posedge clk); #1;
    if (g >= 0) refresh(d, g);
  endtask

  task automatic look(input int d, input logic [4:0] a, input logic [15:0] b,
                      input logic [127:0] w, input logic [1:0] i);
    checks++;
    if (en[d] !== 1'b0 || waddr[d] !== a || wbe[d] !== b || wdata[d] !== w || gidx[d] !== i) begin
      errors++;
      $display("FAIL idle_out dut%0d: got en=%b addr=%0d be=%h data=%h idx=%0d, required en=0 addr=%0d be=%h data=%h idx=%0d",
               d, en[d], waddr[d], wbe[d], wdata[d], gidx[d], a, b, w, i);
    end
  endtask

  int fp_seq [8]  = '{0, 0, 0, 2, 0, 0, 0, 2};
  int rr_seq1 [6] = '{0, 1, 2, 3, 0, 1};
  int rr_seq2 [4] = '{2, 3, 0, 2};

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      blk[d] = 1'b0;
      for (int p = 0; p < 4; p++) refresh(d, p);
    end
    vld[0] = 4'hF; vld[1] = 4'hF; vld[2] = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk_rdy(d, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) vld[d] = 4'b0000;
    for (int d = 0; d < 3; d++) look(d, 5'd0, 16'h0, 128'h0, 2'd0);

    // single pipe, then held outputs on the idle cycle
    paddr[0][2] = 5'd5; pbe[0][2] = 16'hFFFF; pdata[0][2] = {16{8'hA5}};
    vld[0] = 4'b0100;
    step(0, 2);
    vld[0] = 4'b0000;
    step(0, -1);
    look(0, 5'd5, 16'hFFFF, {16{8'hA5}}, 2'd2);

    // fixed priority with aging: pipes 0 and 2
    vld[0] = 4'b0101;
    for (int i = 0; i < 8; i++) step(0, fp_seq[i]);
    vld[0] = 4'b0001;
    step(0, 0);
    vld[0] = 4'b0000;
    step(0, -1);

    // block: counters must freeze across the blocked cycles
    vld[0] = 4'b0011;
    step(0, 0);
    blk[0] = 1'b1;
    repeat (5) step(0, -1);
    blk[0] = 1'b0;
    step(0, 0);
    step(0, 0);
    step(0, 1);
    vld[0] = 4'b0001;
    step(0, 0);
    vld[0] = 4'b0000;
    step(0, -1);

    // reset the cycle after a grant
    vld[0] = 4'b0001;
    step(0, 0);
    vld[0] = 4'b0010;
    rst_n = 1'b0;
    step(0, -1);
    rst_n = 1'b1;
    look(0, 5'd0, 16'h0, 128'h0, 2'd0);
    step(0, 1);
    vld[0] = 4'b0000;
    step(0, -1);

    // round-robin with aging, then pipe 1 withdrawn after its grant
    vld[1] = 4'hF;
    for (int i = 0; i < 6; i++) step(1, rr_seq1[i]);
    vld[1] = 4'b1101;
    for (int i = 0; i < 4; i++) step(1, rr_seq2[i]);
    vld[1] = 4'b1001;
    step(1, 3);
    vld[1] = 4'b0001;
    step(1, 0);
    vld[1] = 4'b0000;
    step(1, -1);

    // zeroed outputs on the idle cycle
    paddr[1][2] = 5'd5; pbe[1][2] = 16'hFFFF; pdata[1][2] = {16{8'hA5}};
    vld[1] = 4'b0100;
    step(1, 2);
    vld[1] = 4'b0000;
    step(1, -1);
    look(1, 5'd0, 16'h0, 128'h0, 2'd0);

    // single-pipe instance: ready follows the block input
    vld[2] = 4'b0001;
    blk[2] = 1'b1;
    step(2, -1);
    step(2, -1);
    blk[2] = 1'b0;
    step(2, 0);
    vld[2] = 4'b0000;
    step(2, -1);
    step(2, -1);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d writes outstanding, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
